cache_arbiter: RTL and testbench

Shares the single physical-memory port between the split L1 instruction and data caches. Each cache issues 128-bit line reads (and, for D-cache, write-backs) as if it owned memory. The arbiter grants one requester at a time, latches its request, drives physical memory and returns the response only to the granted side. It sits between both caches' pmem ports and the memory model or L2.

---
 rtl/cache_arbiter_pkg.sv | 19 +
 rtl/cache_arbiter_control.sv | 61 ++++++
 rtl/cache_arbiter.sv | 80 ++++++++
 tb/tb_cache_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 I/D cache memory-port arbiter.
// Line and address widths are fixed by the LC-3b memory system.
package cache_arbiter_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;

  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [ADDR_W-1:0] lc3b_addr;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} lc3b_arb_state;
  typedef enum logic {ARB_I, ARB_D} lc3b_arb_sel;

  // Memory transfers whole lines, so the byte-in-line offset is dropped.
  function automatic lc3b_addr line_align(input lc3b_addr addr);
    return {addr[ADDR_W-1:4], 4'h0};
  endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: chooses which cache owns the memory port, tracks the last
// grant for tie-breaking and raises the load strobe on the grant edge.
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req_i,
  input  logic          i_req_d,
  input  logic          i_mem_resp,
  output lc3b_arb_state o_state,
  output logic          o_load,
  output lc3b_arb_sel   o_sel
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_next_state;
  lc3b_arb_sel   r_last_grant;
  lc3b_arb_sel   w_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= ARB_D;
    end else begin
      r_state <= w_next_state;
      if (o_load) r_last_grant <= w_grant;
    end
  end

  // Ties go to the side that did not win last time, so grants alternate.
  always_comb begin
    w_next_state = r_state;
    w_grant      = ARB_I;
    case (r_state)
      IDLE: begin
        if (i_req_i && i_req_d) begin
          w_grant      = (r_last_grant == ARB_D) ? ARB_I : ARB_D;
          w_next_state = (w_grant == ARB_I) ? SERVE_I : SERVE_D;
        end else if (i_req_i) begin
          w_grant      = ARB_I;
          w_next_state = SERVE_I;
        end else if (i_req_d) begin
          w_grant      = ARB_D;
          w_next_state = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (i_mem_resp) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_state = r_state;
    o_load  = (r_state == IDLE) && (w_next_state != IDLE);
    o_sel   = w_grant;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache: latches
// the granted request, drives memory from it and routes the response back.
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_pmem_read,
  input  lc3b_addr i_pmem_address,
  output lc3b_line i_pmem_rdata,
  output logic     i_pmem_resp,
  input  logic     d_pmem_read,
  input  logic     d_pmem_write,
  input  lc3b_addr d_pmem_address,
  input  lc3b_line d_pmem_wdata,
  output lc3b_line d_pmem_rdata,
  output logic     d_pmem_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_addr pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  lc3b_arb_state w_state;
  logic          w_load;
  lc3b_arb_sel   w_sel;
  logic          w_d_req;

  lc3b_addr r_addr;
  lc3b_line r_wdata;
  logic     r_op_read;
  logic     r_op_write;

  assign w_d_req = d_pmem_read | d_pmem_write;

  cache_arbiter_control u_control (
    .clk        (clk),
    .reset      (reset),
    .i_req_i    (i_pmem_read),
    .i_req_d    (w_d_req),
    .i_mem_resp (pmem_resp),
    .o_state    (w_state),
    .o_load     (w_load),
    .o_sel      (w_sel)
  );

  // A simultaneous D read+write is served as the write; the read is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op_read  <= 1'b0;
      r_op_write <= 1'b0;
    end else if (w_load) begin
      if (w_sel == ARB_I) begin
        r_addr     <= line_align(i_pmem_address);
        r_op_read  <= 1'b1;
        r_op_write <= 1'b0;
      end else begin
        r_addr     <= line_align(d_pmem_address);
        r_op_read  <= d_pmem_read & ~d_pmem_write;
        r_op_write <= d_pmem_write;
        if (d_pmem_write) r_wdata <= d_pmem_wdata;
      end
    end
  end

  assign pmem_read    = (w_state != IDLE) && r_op_read;
  assign pmem_write   = (w_state != IDLE) && r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  assign i_pmem_resp  = pmem_resp && (w_state == SERVE_I);
  assign d_pmem_resp  = pmem_resp && (w_state == SERVE_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter: reset, single-side transfers,
// tie alternation, request latching, illegal D ops and spurious responses.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] RDATA = 128'hDEADBEEF_01234567_89ABCDEF_0000BEEF;
  localparam logic [127:0] PAT_P = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] PAT_Q = 128'h11223344_55667788_99AABBCC_DDEEFF00;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", pmem_address); end
    checks++; if (pmem_wdata !== 128'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", pmem_wdata); end
    checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp got %b want 00", {i_pmem_resp, d_pmem_resp}); end
    reset = 1'b0;
    d_pmem_write = 1'b1; d_pmem_address = 16'hA0F0; d_pmem_wdata = PAT_P;
    tick();
    checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL pre_reset_write got %b want 1", pmem_write); end
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL midtxn_reset_write got %b want 0", pmem_write); end
    checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL midtxn_reset_addr got %h want 0000", pmem_address); end
    checks++; if (pmem_wdata !== 128'h0) begin errors++; $display("FAIL midtxn_reset_wdata got %h want 0", pmem_wdata); end
    d_pmem_write = 1'b0;
    tick();
    reset = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h1110;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2220;
    tick();
    checks++; if (pmem_address !== 16'h1110) begin errors++; $display("FAIL first_tie_addr got %h want 1110", pmem_address); end
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL first_tie_read got %b want 1", pmem_read); end
    pmem_resp = 1'b1; pmem_rdata = RDATA;
    #1;
    checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin errors++; $display("FAIL first_tie_resp got %b want 10", {i_pmem_resp, d_pmem_resp}); end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick();
    pmem_resp = 1'b0;
    #1;
  endtask

  task automatic test_i_read;
    i_pmem_read = 1'b1; i_pmem_address = 16'h1234;
    tick();
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL iread_strobe got %b want 1", pmem_read); end
    checks++; if (pmem_address !== 16'h1230) begin errors++; $display("FAIL iread_addr got %h want 1230", pmem_address); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL iread_nowrite got %b want 0", pmem_write); end
    repeat (4) tick();
    checks++; if (i_pmem_resp !== 1'b0) begin errors++; $display("FAIL iread_early_resp got %b want 0", i_pmem_resp); end
    pmem_resp = 1'b1; pmem_rdata = RDATA;
    #1;
    checks++; if (i_pmem_resp !== 1'b1) begin errors++; $display("FAIL iread_resp got %b want 1", i_pmem_resp); end
    checks++; if (i_pmem_rdata !== RDATA) begin errors++; $display("FAIL iread_rdata got %h want %h", i_pmem_rdata, RDATA); end
    checks++; if (d_pmem_resp !== 1'b0) begin errors++; $display("FAIL iread_dresp got %b want 0", d_pmem_resp); end
    i_pmem_read = 1'b0;
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++; if ({pmem_read, i_pmem_resp} !== 2'b00) begin errors++; $display("FAIL iread_done got %b want 00", {pmem_read, i_pmem_resp}); end
  endtask

  task automatic test_d_write;
    d_pmem_write = 1'b1; d_pmem_address = 16'hA0F0; d_pmem_wdata = PAT_P;
    tick();
    d_pmem_wdata = PAT_Q;
    for (int c = 0; c < 3; c++) begin
      checks++; if ({pmem_write, pmem_read} !== 2'b10) begin errors++; $display("FAIL dwr_strobe[%0d] got %b want 10", c, {pmem_write, pmem_read}); end
      checks++; if (pmem_address !== 16'hA0F0) begin errors++; $display("FAIL dwr_addr[%0d] got %h want a0f0", c, pmem_address); end
      checks++; if (pmem_wdata !== PAT_P) begin errors++; $display("FAIL dwr_wdata[%0d] got %h want %h", c, pmem_wdata, PAT_P); end
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin errors++; $display("FAIL dwr_resp got %b want 01", {i_pmem_resp, d_pmem_resp}); end
    d_pmem_write = 1'b0;
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++; if ({pmem_write, d_pmem_resp} !== 2'b00) begin errors++; $display("FAIL dwr_done got %b want 00", {pmem_write, d_pmem_resp}); end
  endtask

  task automatic test_back_to_back;
    logic exp_i;
    logic [15:0] exp_addr;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h1110;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2220;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      exp_addr = exp_i ? 16'h1110 : 16'h2220;
      tick();
      checks++; if (pmem_address !== exp_addr) begin errors++; $display("FAIL b2b_addr[%0d] got %h want %h", k, pmem_address, exp_addr); end
      checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL b2b_read[%0d] got %b want 1", k, pmem_read); end
      pmem_resp = 1'b1; pmem_rdata = RDATA;
      #1;
      checks++; if ({i_pmem_resp, d_pmem_resp} !== {exp_i, ~exp_i}) begin errors++; $display("FAIL b2b_resp[%0d] got %b want %b", k, {i_pmem_resp, d_pmem_resp}, {exp_i, ~exp_i}); end
      tick();
      pmem_resp = 1'b0;
      #1;
      checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d] got %b want 0", k, pmem_read); end
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_hold_latched;
    i_pmem_read = 1'b1; i_pmem_address = 16'h4567;
    tick();
    i_pmem_address = 16'h7770; i_pmem_read = 1'b0;
    tick();
    checks++; if (pmem_address !== 16'h4560) begin errors++; $display("FAIL hold_addr got %h want 4560", pmem_address); end
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL hold_read got %b want 1", pmem_read); end
    pmem_resp = 1'b1;
    #1;
    checks++; if (i_pmem_resp !== 1'b1) begin errors++; $display("FAIL hold_resp got %b want 1", i_pmem_resp); end
    tick();
    pmem_resp = 1'b0;
    #1;
  endtask

  task automatic test_illegal_and_spurious;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 16'h0BC7; d_pmem_wdata = PAT_Q;
    tick();
    checks++; if ({pmem_write, pmem_read} !== 2'b10) begin errors++; $display("FAIL illegal_op got %b want 10", {pmem_write, pmem_read}); end
    checks++; if (pmem_address !== 16'h0BC0) begin errors++; $display("FAIL illegal_addr got %h want 0bc0", pmem_address); end
    checks++; if (pmem_wdata !== PAT_Q) begin errors++; $display("FAIL illegal_wdata got %h want %h", pmem_wdata, PAT_Q); end
    pmem_resp = 1'b1; pmem_rdata = PAT_P;
    #1;
    checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin errors++; $display("FAIL illegal_resp got %b want 01", {i_pmem_resp, d_pmem_resp}); end
    checks++; if (d_pmem_rdata !== PAT_P) begin errors++; $display("FAIL illegal_rdata got %h want %h", d_pmem_rdata, PAT_P); end
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    tick();
    pmem_resp = 1'b0;
    tick();
    pmem_resp = 1'b1;
    #1;
    checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin errors++; $display("FAIL spurious_resp got %b want 00", {i_pmem_resp, d_pmem_resp}); end
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL spurious_strobes got %b want 00", {pmem_read, pmem_write}); end
  endtask

  initial begin
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    test_reset();
    test_i_read();
    test_d_write();
    test_back_to_back();
    test_hold_latched();
    test_illegal_and_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
